// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants, writeback request type and address decode helper
package regfile_pkg;

    localparam logic [3:0] REG_PC  = 4'hF;
    localparam int         NUM_GPR = 15;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wb_req_t;

    function automatic logic [NUM_GPR-1:0] reg_onehot(input logic v, input logic [3:0] a);
        return (v && a != REG_PC) ? (NUM_GPR'(1) << a) : '0;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// wb_slot: one-entry writeback holding buffer, drained by grant and emptied by clear
module wb_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              pop,
    input  logic              clear,
    output logic              full,
    output logic [3:0]        addr,
    output logic [DATA_W-1:0] data,
    output logic              full_nxt,
    output logic [3:0]        addr_nxt
);

    logic              full_q, full_d;
    logic [3:0]        addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load;

    always_comb begin
        in_ready = (!full_q || pop) && !clear;
        load     = in_valid && in_ready;
        full_d   = load || (full_q && !pop && !clear);
        addr_d   = load ? in_addr : addr_q;
        data_d   = load ? in_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full     = full_q;
    assign addr     = addr_q;
    assign data     = data_q;
    assign full_nxt = full_d;
    assign addr_nxt = addr_d;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates EX and MEM writebacks onto the single register-file write port
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [3:0]         ex_addr,
    input  logic [DATA_W-1:0]  ex_data,
    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic [3:0]         mem_addr,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               flush,
    output logic               WE3,
    output logic [3:0]         A3,
    output logic [DATA_W-1:0]  WD3,
    output logic               pc_wr_valid,
    output logic [DATA_W-1:0]  pc_wr_data,
    output logic [NUM_GPR-1:0] pend_mask
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic              ex_full, mem_full, ex_full_nxt, mem_full_nxt;
    logic [3:0]        ex_addr_s, mem_addr_s, ex_addr_nxt, mem_addr_nxt;
    logic [DATA_W-1:0] ex_data_s, mem_data_s;
    logic              ex_win, mem_win, any_win;
    logic [3:0]        win_addr;
    logic [DATA_W-1:0] win_data;

    logic               ex_older_q, ex_older_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic               we_q, we_d, pcv_q, pcv_d;
    logic [3:0]         a3_q, a3_d;
    logic [DATA_W-1:0]  wd3_q, wd3_d, pcd_q, pcd_d;
    logic [NUM_GPR-1:0] pend_q, pend_d;

    wb_slot #(.DATA_W(DATA_W)) u_ex_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (ex_valid),
        .in_ready (ex_ready),
        .in_addr  (ex_addr),
        .in_data  (ex_data),
        .pop      (ex_win),
        .clear    (flush),
        .full     (ex_full),
        .addr     (ex_addr_s),
        .data     (ex_data_s),
        .full_nxt (ex_full_nxt),
        .addr_nxt (ex_addr_nxt)
    );

    wb_slot #(.DATA_W(DATA_W)) u_mem_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (mem_valid),
        .in_ready (mem_ready),
        .in_addr  (mem_addr),
        .in_data  (mem_data),
        .pop      (mem_win),
        .clear    (1'b0),
        .full     (mem_full),
        .addr     (mem_addr_s),
        .data     (mem_data_s),
        .full_nxt (mem_full_nxt),
        .addr_nxt (mem_addr_nxt)
    );

    // Same-address pairs keep program order; otherwise MEM is favoured until EX has starved long enough.
    always_comb begin
        ex_win     = ex_full && !flush &&
                     (!mem_full || ((ex_addr_s == mem_addr_s) ? ex_older_q : (starve_q == SW'(STARVE_LIMIT))));
        mem_win    = mem_full && !ex_win;
        any_win    = ex_win || mem_win;
        win_addr   = ex_win ? ex_addr_s : mem_addr_s;
        win_data   = ex_win ? ex_data_s : mem_data_s;
        starve_d   = (!ex_full || flush || ex_win) ? '0 :
                     (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
        ex_older_d = (ex_valid && ex_ready) ? 1'b0 : (mem_valid && mem_ready) ? 1'b1 : ex_older_q;
        we_d       = any_win && win_addr != REG_PC;
        pcv_d      = any_win && win_addr == REG_PC;
        a3_d       = we_d ? win_addr : a3_q;
        wd3_d      = we_d ? win_data : wd3_q;
        pcd_d      = pcv_d ? win_data : pcd_q;
        pend_d     = reg_onehot(ex_full_nxt, ex_addr_nxt) | reg_onehot(mem_full_nxt, mem_addr_nxt) |
                     reg_onehot(we_d, a3_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_older_q <= 1'b0;
            starve_q   <= '0;
            we_q       <= 1'b0;
            pcv_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
            pcd_q      <= '0;
            pend_q     <= '0;
        end else begin
            ex_older_q <= ex_older_d;
            starve_q   <= starve_d;
            we_q       <= we_d;
            pcv_q      <= pcv_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
            pcd_q      <= pcd_d;
            pend_q     <= pend_d;
        end
    end

    assign WE3         = we_q;
    assign A3          = a3_q;
    assign WD3         = wd3_q;
    assign pc_wr_valid = pcv_q;
    assign pc_wr_data  = pcd_q;
    assign pend_mask   = pend_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    typedef struct packed {
        logic    pc;
        wb_req_t req;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, mem_valid = 1'b0, flush = 1'b0;
    logic        ex_ready, mem_ready;
    logic [3:0]  ex_addr = '0, mem_addr = '0;
    logic [31:0] ex_data = '0, mem_data = '0;
    logic        WE3, pc_wr_valid;
    logic [3:0]  A3;
    logic [31:0] WD3, pc_wr_data;
    logic [14:0] pend_mask;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_addr     (ex_addr),
        .ex_data     (ex_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .flush       (flush),
        .WE3         (WE3),
        .A3          (A3),
        .WD3         (WD3),
        .pc_wr_valid (pc_wr_valid),
        .pc_wr_data  (pc_wr_data),
        .pend_mask   (pend_mask)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic pc, input logic [3:0] addr, input logic [31:0] data);
        exp_t e;
        e.pc       = pc;
        e.req.addr = addr;
        e.req.data = data;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && (WE3 || pc_wr_valid)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: got WE3=%b pc_wr_valid=%b A3=%h expected no write", WE3, pc_wr_valid, A3);
            end else begin
                mon_e = q.pop_front();
                chk("issue_pc", 32'(pc_wr_valid), 32'(mon_e.pc));
                chk("issue_we3", 32'(WE3), 32'(!mon_e.pc));
                if (mon_e.pc) chk("pc_wr_data", pc_wr_data, mon_e.req.data);
                else begin
                    chk("a3", 32'(A3), 32'(mon_e.req.addr));
                    chk("wd3", WD3, mon_e.req.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ei, mi;
        logic exg, memg;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_we3", 32'(WE3), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd3", WD3, 32'd0);
        chk("rst_pcv", 32'(pc_wr_valid), 32'd0);
        chk("rst_pcd", pc_wr_data, 32'd0);
        chk("rst_pend", 32'(pend_mask), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);

        ex_valid = 1'b1; ex_addr = 4'd3; ex_data = 32'hDEADBEEF;
        push_exp(1'b0, 4'd3, 32'hDEADBEEF);
        step();
        ex_valid = 1'b0;
        chk("single_pend_e0", 32'(pend_mask), 32'h8);
        step();
        chk("single_pend_e1", 32'(pend_mask), 32'h8);
        chk("single_we3_e1", 32'(WE3), 32'd1);
        step();
        chk("single_pend_e2", 32'(pend_mask), 32'h0);
        chk("single_we3_e2", 32'(WE3), 32'd0);

        ex_valid = 1'b1; ex_addr = 4'd5; ex_data = 32'h0000_00E5;
        mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 32'h0000_0035;
        push_exp(1'b0, 4'd5, 32'h35);
        push_exp(1'b0, 4'd5, 32'hE5);
        step();
        ex_valid = 1'b0; mem_valid = 1'b0;
        chk("same_addr_pend", 32'(pend_mask), 32'h20);
        repeat (3) step();
        chk("same_addr_pend_drain", 32'(pend_mask), 32'h0);

        push_exp(1'b0, 4'd2, 32'hA0);
        push_exp(1'b0, 4'd2, 32'hA1);
        push_exp(1'b0, 4'd2, 32'hA2);
        push_exp(1'b0, 4'd2, 32'hA3);
        push_exp(1'b0, 4'd1, 32'hE0);
        push_exp(1'b0, 4'd2, 32'hA4);
        push_exp(1'b0, 4'd2, 32'hA5);
        push_exp(1'b0, 4'd1, 32'hE1);
        ei = 0; mi = 0;
        for (int c = 0; c < 12; c++) begin
            ex_valid  = ei < 2; ex_addr  = 4'd1; ex_data  = 32'hE0 + 32'(ei);
            mem_valid = mi < 6; mem_addr = 4'd2; mem_data = 32'hA0 + 32'(mi);
            #1;
            exg  = ex_valid && ex_ready;
            memg = mem_valid && mem_ready;
            step();
            if (exg) ei++;
            if (memg) mi++;
        end
        ex_valid = 1'b0; mem_valid = 1'b0;
        chk("starve_ex_sent", 32'(ei), 32'd2);
        chk("starve_mem_sent", 32'(mi), 32'd6);
        step();

        mem_valid = 1'b1; mem_addr = 4'hF; mem_data = 32'h100;
        push_exp(1'b1, 4'hF, 32'h100);
        step();
        mem_valid = 1'b0;
        chk("pc_pend_e0", 32'(pend_mask), 32'h0);
        step();
        chk("pc_valid_e1", 32'(pc_wr_valid), 32'd1);
        chk("pc_we3_e1", 32'(WE3), 32'd0);
        chk("pc_pend_e1", 32'(pend_mask), 32'h0);
        step();
        chk("pc_valid_e2", 32'(pc_wr_valid), 32'd0);

        ex_valid = 1'b1; ex_addr = 4'd7; ex_data = 32'h77;
        step();
        ex_valid = 1'b0;
        chk("flush_pend_before", 32'(pend_mask), 32'h80);
        flush = 1'b1;
        #1;
        chk("flush_ex_ready", 32'(ex_ready), 32'd0);
        step();
        flush = 1'b0;
        chk("flush_pend_after", 32'(pend_mask), 32'h0);
        chk("flush_we3", 32'(WE3), 32'd0);
        step();

        ex_valid = 1'b1; ex_addr = 4'd8; ex_data = 32'h88;
        mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 32'h99;
        step();
        ex_valid = 1'b0; mem_valid = 1'b0;
        chk("rst2_pend_before", 32'(pend_mask), 32'h300);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_we3", 32'(WE3), 32'd0);
        chk("rst2_pend", 32'(pend_mask), 32'h0);
        chk("rst2_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst2_mem_ready", 32'(mem_ready), 32'd1);
        repeat (3) step();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
